// File: rtl/tmr_sipo_receiver.sv
// rtl/tmr_sipo_receiver.sv - triplicated serial-in/parallel-out receiver with voted scrubbing
module tmr_sipo_receiver #(
  parameter int width     = 4,
  parameter bit lsb_first = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             sin_valid,
  input  logic             serial_in,
  input  logic             out_ready,
  output logic [width-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             mismatch
);

  localparam int cw = $clog2(width);

  // One full copy of the receiver state; the three copies are voted as flat vectors.
  typedef struct packed {
    logic             ovr;
    logic             vld;
    logic [width-1:0] obuf;
    logic [cw-1:0]    cnt;
    logic [width-1:0] sr;
  } st_t;

  st_t st0, st1, st2;
  st_t cur;
  st_t nxt0, nxt1, nxt2;
  st_t nxt_v;

  // Bitwise two-out-of-three vote across copies.
  function automatic st_t maj(input st_t a, input st_t b, input st_t c);
    return st_t'((a & b) | (a & c) | (b & c));
  endfunction

  // Next state of a single copy, evaluated independently before voting.
  function automatic st_t step(input st_t s, input logic en, input logic clr,
                               input logic sv, input logic si, input logic rdy);
    st_t              n;
    logic             xfer;
    logic [width-1:0] sh;
    n    = s;
    xfer = s.vld & rdy;
    sh   = lsb_first ? {si, s.sr[width-1:1]} : {s.sr[width-2:0], si};
    if (clr) begin
      n.sr  = '0;
      n.cnt = '0;
      n.vld = 1'b0;
      n.ovr = 1'b0;
    end else begin
      if (xfer) n.vld = 1'b0;
      if (en & sv) begin
        n.sr = sh;
        if (s.cnt == cw'(width - 1)) begin
          n.cnt = '0;
          // A completed word only lands if the buffer is empty or draining this edge.
          if (!s.vld || xfer) begin
            n.obuf = sh;
            n.vld  = 1'b1;
          end else begin
            n.ovr = 1'b1;
          end
        end else begin
          n.cnt = s.cnt + cw'(1);
        end
      end
    end
    return n;
  endfunction

  assign nxt0  = step(st0, enable, clear, sin_valid, serial_in, out_ready);
  assign nxt1  = step(st1, enable, clear, sin_valid, serial_in, out_ready);
  assign nxt2  = step(st2, enable, clear, sin_valid, serial_in, out_ready);
  assign nxt_v = maj(nxt0, nxt1, nxt2);
  assign cur   = maj(st0, st1, st2);

  // Every copy is rewritten with the voted next state each cycle, scrubbing single upsets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st0 <= '0;
      st1 <= '0;
      st2 <= '0;
    end else begin
      st0 <= nxt_v;
      st1 <= nxt_v;
      st2 <= nxt_v;
    end
  end

  assign parallel_out = cur.obuf;
  assign out_valid    = cur.vld;
  assign overrun      = cur.ovr;
  assign mismatch     = (st0 != st1) || (st1 != st2);

endmodule

// File: tb/tb_tmr_sipo_receiver.sv
// tb/tb_tmr_sipo_receiver.sv - randomized and directed bench for tmr_sipo_receiver
module tb_tmr_sipo_receiver;

  localparam int W  = 4;
  localparam int SW = 2 * W + 2 + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0, clear = 1'b0, sin_valid = 1'b0, serial_in = 1'b0, out_ready = 1'b0;
  logic [W-1:0] po_l, po_m;
  logic ov_l, ov_m, or_l, or_m, mm_l, mm_m;
  logic [SW-1:0] tmp;

  int errors = 0;
  int checks = 0;

  bit         mbits[$];
  logic       mvld, movr;
  logic [W-1:0] mbuf_l, mbuf_m;

  always #5 clk = ~clk;

  tmr_sipo_receiver #(.width(W), .lsb_first(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .sin_valid(sin_valid),
    .serial_in(serial_in), .out_ready(out_ready), .parallel_out(po_l),
    .out_valid(ov_l), .overrun(or_l), .mismatch(mm_l));

  tmr_sipo_receiver #(.width(W), .lsb_first(1'b0)) u_msb (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .sin_valid(sin_valid),
    .serial_in(serial_in), .out_ready(out_ready), .parallel_out(po_m),
    .out_valid(ov_m), .overrun(or_m), .mismatch(mm_m));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mbits.delete();
    mvld   = 1'b0;
    movr   = 1'b0;
    mbuf_l = '0;
    mbuf_m = '0;
  endtask

  // Reference: collect accepted bits in a list; every W bits forms a word in both bit orders.
  task automatic model_step();
    logic v0, xfer;
    int   wl, wm;
    if (clear) begin
      mbits.delete();
      mvld = 1'b0;
      movr = 1'b0;
    end else begin
      v0   = mvld;
      xfer = v0 && out_ready;
      if (xfer) mvld = 1'b0;
      if (enable && sin_valid) begin
        mbits.push_back(serial_in);
        if (mbits.size() == W) begin
          wl = 0;
          wm = 0;
          for (int i = 0; i < W; i++) begin
            wl += int'(mbits[i]) * (1 << i);
            wm += int'(mbits[i]) * (1 << (W - 1 - i));
          end
          mbits.delete();
          if (!v0 || xfer) begin
            mbuf_l = W'(wl);
            mbuf_m = W'(wm);
            mvld   = 1'b1;
          end else begin
            movr = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("pout_lsb", po_l, mbuf_l);
    check("valid_lsb", ov_l, mvld);
    check("ovr_lsb", or_l, movr);
    check("mism_lsb", mm_l, 1'b0);
    check("pout_msb", po_m, mbuf_m);
    check("valid_msb", ov_m, mvld);
    check("ovr_msb", or_m, movr);
    check("mism_msb", mm_m, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic sv, input logic si,
                       input logic rdy, input logic clr);
    enable    = en;
    sin_valid = sv;
    serial_in = si;
    out_ready = rdy;
    clear     = clr;
    tick();
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy);
    for (int i = 0; i < W; i++) drive(1'b1, 1'b1, w[i], rdy, 1'b0);
  endtask

  task automatic idle_drain();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_pout", po_l, 4'h0);
    check("reset_valid", ov_l, 1'b0);
    check("reset_ovr", or_l, 1'b0);
    check("reset_mism", mm_l, 1'b0);
    rst = 1'b1;

    // basic word, bits 1,0,1,1
    send_word(4'hD, 1'b0);
    check("basic_lsb", po_l, 4'hD);
    check("basic_msb", po_m, 4'hB);
    check("basic_valid", ov_l, 1'b1);
    idle_drain();
    check("drained", ov_l, 1'b0);

    // back-to-back with consumer always ready
    send_word(4'hA, 1'b1);
    check("b2b_first", po_l, 4'hA);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("b2b_pulse", ov_l, 1'b0);
    for (int i = 1; i < W; i++) drive(1'b1, 1'b1, (i % 2) == 0, 1'b1, 1'b0);
    check("b2b_second", po_l, 4'h5);
    check("b2b_noovr", or_l, 1'b0);
    idle_drain();

    // overrun with consumer stalled
    send_word(4'h3, 1'b0);
    send_word(4'hC, 1'b0);
    check("ovr_keep", po_l, 4'h3);
    check("ovr_flag", or_l, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_ovr", or_l, 1'b0);
    check("clr_valid", ov_l, 1'b0);

    // drain on the completion edge
    send_word(4'h3, 1'b0);
    for (int i = 0; i < W; i++) drive(1'b1, 1'b1, i >= 2, i == W - 1, 1'b0);
    check("simul_word", po_l, 4'hC);
    check("simul_valid", ov_l, 1'b1);
    check("simul_noovr", or_l, 1'b0);
    idle_drain();

    // gaps mid-word: 0x6 = bits 0,1,1,0
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("gap_word", po_l, 4'h6);
    idle_drain();

    // clear after two bits
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    send_word(4'h9, 1'b0);
    check("clear_word", po_l, 4'h9);

    // asynchronous reset mid-word while a word is pending
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("arst_pout", po_l, 4'h0);
    check("arst_valid", ov_l, 1'b0);
    check("arst_ovr", or_l, 1'b0);
    check("arst_pout_m", po_m, 4'h0);
    model_reset();
    #1 rst = 1'b1;
    send_word(4'h5, 1'b0);
    check("post_rst_word", po_l, 4'h5);
    idle_drain();

    // single-copy upset in a shift-register bit mid-word (0xE = bits 0,1,1,1)
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tmp = u_lsb.st1 ^ SW'(2);
    force u_lsb.st1 = tmp;
    #1 release u_lsb.st1;
    check("upset_sr_mism", mm_l, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("upset_sr_word", po_l, 4'hE);
    idle_drain();

    // single-copy upset in out_valid while empty
    tmp = u_lsb.st2 ^ (SW'(1) << (2 * W + 2));
    force u_lsb.st2 = tmp;
    #1 release u_lsb.st2;
    check("upset_vld_mism", mm_l, 1'b1);
    check("upset_vld_out", ov_l, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("upset_vld_after", ov_l, 1'b0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, 1'($urandom),
            1'($urandom), $urandom_range(0, 40) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
